// File: rtl/seq_gen.sv
// Serial frame generator: sync word, then payload MSB first, then idle gap.
// Optional SEQ_GEN_PARITY_EN appends an even-parity bit after the payload.
module seq_gen #(
  parameter int unsigned        DATA_W  = 8,
  parameter int unsigned        SYNC_W  = 4,
  parameter logic [SYNC_W-1:0]  SYNC    = 4'b1101,
  parameter int unsigned        GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              dout,
  output logic              dval,
  output logic              done
);

  localparam int unsigned MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MAX_W  = (MAX_SD > GAP_CYC) ? MAX_SD : GAP_CYC;
  localparam int unsigned CNT_W  = $clog2(MAX_W) + 1;

`ifdef SEQ_GEN_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic               par_q, par_d;
  logic               dout_d, dval_d, done_d, ready_d;

  // State, datapath and registered outputs; outputs are pre-computed from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      ready   <= 1'b1;
      dout    <= 1'b0;
      dval    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      ready   <= ready_d;
      dout    <= dout_d;
      dval    <= dval_d;
      done    <= done_d;
    end
  end

  // Next state; cnt holds remaining cycles in the current state and reloads on each transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SYNC;
          cnt_d   = CNT_W'(SYNC_W - 1);
          sh_d    = din;
          par_d   = ^din;
        end
      end
      S_SYNC: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PAR;
          cnt_d   = '0;
`else
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CYC - 1);
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        state_d = S_GAP;
        cnt_d   = CNT_W'(GAP_CYC - 1);
      end
`endif
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode of the upcoming cycle
  always_comb begin
    dout_d  = 1'b0;
    dval_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = (state_d == S_IDLE);
    unique case (state_d)
      S_SYNC: begin
        dout_d = |((SYNC_W'(1) << cnt_d) & SYNC);
        dval_d = 1'b1;
      end
      S_DATA: begin
        dout_d = sh_d[DATA_W-1];
        dval_d = 1'b1;
`ifndef SEQ_GEN_PARITY_EN
        done_d = (cnt_d == '0);
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        dout_d = par_d;
        dval_d = 1'b1;
        done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed testbench for seq_gen at default parameters; honours SEQ_GEN_PARITY_EN.
module tb_seq_gen;

`ifdef SEQ_GEN_PARITY_EN
  localparam int FL = 13;
`else
  localparam int FL = 12;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, dout, dval, done;

  int checks = 0;
  int errors = 0;

  // A5 frame: sync 1101, data 10100101, parity 0
  logic [12:0] exp_a5 = 13'b1101_1010_0101_0;

  seq_gen dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .ready (ready),
    .dout  (dout),
    .dval  (dval),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; din = 8'hFF;
    step(); step();
    checks++;
    if ({ready, dout, dval, done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state got rdy/dout/dval/done=%b exp 1000", {ready, dout, dval, done});
    end
    rst = 1'b0; load = 1'b0; din = 8'h00;
    step();
    checks++;
    if (ready !== 1'b1 || dval !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b dval=%b exp 1 0", ready, dval);
    end
  endtask

  // Runs one A5 frame; optionally pulses load with FF in cycle 5
  task automatic run_a5(input bit inject, input string tag);
    load = 1'b1; din = 8'hA5;
    step();
    load = 1'b0; din = 8'h00;
    for (int i = 1; i <= FL; i++) begin
      checks++;
      if (dout !== exp_a5[13-i] || dval !== 1'b1 || done !== (i == FL) || ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_bit%0d got dout=%b dval=%b done=%b ready=%b exp dout=%b dval=1 done=%b ready=0",
                 tag, i, dout, dval, done, ready, exp_a5[13-i], (i == FL));
      end
      if (inject && i == 5) begin load = 1'b1; din = 8'hFF; end
      else begin load = 1'b0; din = 8'h00; end
      step();
    end
    load = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      checks++;
      if (dout !== 1'b0 || dval !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_gap%0d got dout=%b dval=%b done=%b ready=%b exp 0 0 0 0",
                 tag, i, dout, dval, done, ready);
      end
      step();
    end
    checks++;
    if (ready !== 1'b1 || dval !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready got ready=%b dval=%b exp 1 0", tag, ready, dval);
    end
  endtask

  task automatic test_frame();
    run_a5(1'b0, "frame_a5");
  endtask

  task automatic test_load_ignored();
    run_a5(1'b1, "load_ignored");
  endtask

  task automatic test_reset_mid();
    load = 1'b1; din = 8'hA5;
    step();
    load = 1'b0;
    for (int i = 1; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 8; i <= 20; i++) begin
      checks++;
      if (ready !== 1'b1 || dout !== 1'b0 || dval !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_c%0d got rdy/dout/dval/done=%b exp 1000", i, {ready, dout, dval, done});
      end
      step();
    end
  endtask

`ifdef SEQ_GEN_PARITY_EN
  task automatic test_parity();
    load = 1'b1; din = 8'h01;
    step();
    load = 1'b0;
    for (int i = 1; i < 13; i++) step();
    checks++;
    if (dout !== 1'b1 || dval !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL parity_01 got dout=%b dval=%b done=%b exp 1 1 1", dout, dval, done);
    end
    for (int i = 0; i < 3; i++) step();
  endtask
`endif

  task automatic test_back_to_back();
    int       done_cnt = 0;
    int       d1 = 0;
    int       d2 = 0;
    int       det = 0;
    logic [3:0] win = 4'b0000;
    load = 1'b1; din = 8'h3C;
    step();
    for (int c = 1; c <= 2 * (FL + 3); c++) begin
      win = {win[2:0], dout};
      if (dval && win == 4'b1101) det++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) d1 = c; else d2 = c;
      end
      if (c == FL + 3) begin
        checks++;
        if (ready !== 1'b1 || dval !== 1'b0) begin
          errors++;
          $display("FAIL b2b_accept_cycle got ready=%b dval=%b exp 1 0", ready, dval);
        end
      end
      if (c == FL + 4) begin
        checks++;
        if (dout !== 1'b1 || dval !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_sync got dout=%b dval=%b exp 1 1", dout, dval);
        end
      end
      if (c == 2 * (FL + 3)) load = 1'b0;
      step();
    end
    checks++;
    if (done_cnt != 2 || d1 != FL || d2 - d1 != FL + 3) begin
      errors++;
      $display("FAIL b2b_done got cnt=%0d at %0d,%0d exp cnt=2 at %0d,%0d", done_cnt, d1, d2, FL, 2 * FL + 3);
    end
    checks++;
    if (det != 2) begin
      errors++;
      $display("FAIL b2b_sync_detect got %0d exp 2", det);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_frame();
    step();
    test_load_ignored();
    step();
    test_reset_mid();
`ifdef SEQ_GEN_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
